dcache_controller: RTL and testbench

//  Control FSM for the direct-mapped, write-back, write-allocate dcache datapath.

---
 rtl/dcache_controller.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - dcache control FSM; optional perf counters under DCACHE_PERF_COUNTERS_EN
module dcache_controller #(
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pipe_req_valid,
    input  logic [1:0]                pipe_req_type,
    output logic                      pipe_req_fulfilled,
    output logic                      l2_req_valid,
    output logic                      l2_req_store,
    input  logic                      l2_req_fulfilled,
    input  logic                      valid_block_match,
    input  logic                      valid_dirty_bit,
    input  logic                      counter_done,
    output logic                      flush_mode,
    output logic                      load_mode,
    output logic                      perform_write,
    output logic                      set_selected_dirty_bit,
    output logic                      clear_selected_dirty_bit,
    output logic                      clear_selected_valid_bit,
    output logic                      finish_new_line_install,
    output logic                      set_new_l2_block_address,
    output logic                      use_dirty_tag_for_l2_block_address,
    output logic                      reset_counter,
    output logic                      decrement_counter
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_hits,
    output logic [PERF_CNT_WIDTH-1:0] perf_misses,
    output logic [PERF_CNT_WIDTH-1:0] perf_wbacks
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    localparam logic [1:0] REQ_STORE   = 2'd1;
    localparam logic [1:0] REQ_CLFLUSH = 2'd2;

    state_t     state_q, state_d;
    logic [1:0] type_q, type_d;
    logic       is_store, is_flush;

    if (PERF_CNT_WIDTH < 1) begin : g_bad_width
        $error("PERF_CNT_WIDTH must be at least 1");
    end

    // The request type is captured on acceptance so a misbehaving pipe cannot redirect a burst.
    assign is_store = (type_q == REQ_STORE);
    assign is_flush = (type_q == REQ_CLFLUSH);

    // State and captured request type registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            type_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
        end
    end

    // Next-state and Mealy strobe decode.
    always_comb begin
        state_d                            = state_q;
        type_d                             = type_q;
        pipe_req_fulfilled                 = 1'b0;
        l2_req_valid                       = 1'b0;
        l2_req_store                       = 1'b0;
        flush_mode                         = 1'b0;
        load_mode                          = 1'b0;
        perform_write                      = 1'b0;
        set_selected_dirty_bit             = 1'b0;
        clear_selected_dirty_bit           = 1'b0;
        clear_selected_valid_bit           = 1'b0;
        finish_new_line_install            = 1'b0;
        set_new_l2_block_address           = 1'b0;
        use_dirty_tag_for_l2_block_address = 1'b0;
        reset_counter                      = 1'b0;
        decrement_counter                  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pipe_req_valid) begin
                    type_d  = pipe_req_type;
                    state_d = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (is_flush) begin
                    if (valid_block_match && valid_dirty_bit) begin
                        // Dirty line must reach L2 before it can be dropped.
                        set_new_l2_block_address           = 1'b1;
                        use_dirty_tag_for_l2_block_address = 1'b1;
                        reset_counter                      = 1'b1;
                        state_d                            = S_WRITEBACK;
                    end else begin
                        clear_selected_valid_bit = valid_block_match;
                        pipe_req_fulfilled       = 1'b1;
                        state_d                  = S_IDLE;
                    end
                end else if (valid_block_match) begin
                    pipe_req_fulfilled     = 1'b1;
                    perform_write          = is_store;
                    set_selected_dirty_bit = is_store;
                    state_d                = S_IDLE;
                end else begin
                    set_new_l2_block_address = 1'b1;
                    reset_counter            = 1'b1;
                    if (valid_dirty_bit) begin
                        use_dirty_tag_for_l2_block_address = 1'b1;
                        state_d                            = S_WRITEBACK;
                    end else begin
                        // Invalidate now so an interrupted refill never leaves a half-filled valid line.
                        clear_selected_valid_bit = 1'b1;
                        state_d                  = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                flush_mode   = 1'b1;
                l2_req_valid = 1'b1;
                l2_req_store = 1'b1;
                if (l2_req_fulfilled) begin
                    if (!counter_done) begin
                        decrement_counter = 1'b1;
                    end else begin
                        clear_selected_dirty_bit = 1'b1;
                        clear_selected_valid_bit = 1'b1;
                        if (is_flush) begin
                            pipe_req_fulfilled = 1'b1;
                            state_d            = S_IDLE;
                        end else begin
                            set_new_l2_block_address = 1'b1;
                            reset_counter            = 1'b1;
                            state_d                  = S_ALLOCATE;
                        end
                    end
                end
            end

            S_ALLOCATE: begin
                load_mode    = 1'b1;
                l2_req_valid = 1'b1;
                if (l2_req_fulfilled) begin
                    perform_write = 1'b1;
                    if (!counter_done) begin
                        decrement_counter = 1'b1;
                    end else begin
                        // Line is complete; replay the request through COMPARE where it now hits.
                        finish_new_line_install = 1'b1;
                        state_d                 = S_COMPARE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic                      replay_q;
    logic [PERF_CNT_WIDTH-1:0] perf_hits_q, perf_misses_q, perf_wbacks_q;
    logic                      hit_ev, miss_ev, wback_ev;

    assign hit_ev   = (state_q == S_COMPARE) && !is_flush && valid_block_match && !replay_q;
    assign miss_ev  = (state_q == S_COMPARE) && !is_flush && !valid_block_match;
    assign wback_ev = (state_q == S_COMPARE) && (state_d == S_WRITEBACK);

    // Replay flag marks the COMPARE that follows a refill so its hit is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            replay_q <= 1'b0;
        end else if (state_q == S_ALLOCATE && state_d == S_COMPARE) begin
            replay_q <= 1'b1;
        end else if (state_q == S_COMPARE) begin
            replay_q <= 1'b0;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
            perf_wbacks_q <= '0;
        end else begin
            if (hit_ev && perf_hits_q != '1)     perf_hits_q   <= perf_hits_q + 1'b1;
            if (miss_ev && perf_misses_q != '1)  perf_misses_q <= perf_misses_q + 1'b1;
            if (wback_ev && perf_wbacks_q != '1) perf_wbacks_q <= perf_wbacks_q + 1'b1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
    assign perf_wbacks = perf_wbacks_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
`timescale 1ns/1ps
module tb_dcache_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       pipe_req_valid;
    logic [1:0] pipe_req_type;
    logic       pipe_req_fulfilled;
    logic       l2_req_valid, l2_req_store, l2_req_fulfilled;
    logic       valid_block_match, valid_dirty_bit, counter_done;
    logic       flush_mode, load_mode, perform_write;
    logic       set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit;
    logic       finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address;
    logic       reset_counter, decrement_counter;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] perf_hits, perf_misses, perf_wbacks;
`endif

    dcache_controller #(.PERF_CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
        .pipe_req_fulfilled(pipe_req_fulfilled),
        .l2_req_valid(l2_req_valid), .l2_req_store(l2_req_store), .l2_req_fulfilled(l2_req_fulfilled),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit), .counter_done(counter_done),
        .flush_mode(flush_mode), .load_mode(load_mode), .perform_write(perform_write),
        .set_selected_dirty_bit(set_selected_dirty_bit), .clear_selected_dirty_bit(clear_selected_dirty_bit),
        .clear_selected_valid_bit(clear_selected_valid_bit), .finish_new_line_install(finish_new_line_install),
        .set_new_l2_block_address(set_new_l2_block_address),
        .use_dirty_tag_for_l2_block_address(use_dirty_tag_for_l2_block_address),
        .reset_counter(reset_counter), .decrement_counter(decrement_counter)
`ifdef DCACHE_PERF_COUNTERS_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbacks(perf_wbacks)
`endif
    );

    wire [13:0] outs = {pipe_req_fulfilled, l2_req_valid, l2_req_store, flush_mode, load_mode, perform_write,
                        set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit,
                        finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address,
                        reset_counter, decrement_counter};

    localparam int WORDS = 8;
    localparam int SETS  = 4;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Datapath emulation: metadata and word counter driven only by DUT strobes.
    bit dp_valid [SETS];
    int dp_tag   [SETS];
    bit dp_dirty [SETS];
    int dp_cnt;
    // Reference cache state: evolved from request semantics alone.
    bit rf_valid [SETS];
    int rf_tag   [SETS];
    bit rf_dirty [SETS];
    longint exp_hits, exp_misses, exp_wbacks;
    // L2 responder.
    bit l2_busy;
    int l2_wait;
    bit l2_store_lat;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef DCACHE_PERF_COUNTERS_EN
        chk({tag, "_perf_hits"}, perf_hits, exp_hits);
        chk({tag, "_perf_misses"}, perf_misses, exp_misses);
        chk({tag, "_perf_wbacks"}, perf_wbacks, exp_wbacks);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic do_req(input logic [1:0] typ, input int s, input int t, input bit abort);
        bit    is_store, is_flush, hit, dirty, done, aborted;
        int    e_st, e_ld, e_wr, e_nd, e_nc, e_fin;
        int    n_st, n_ld, n_wr, n_nd, n_nc, n_fin, proto, cyc, ful_cyc;
        string nm;
        nm = $sformatf("t%0d", txn);
        txn++;
        is_store = (typ == 2'd1);
        is_flush = (typ == 2'd2);
        hit   = rf_valid[s] && (rf_tag[s] == t);
        dirty = rf_valid[s] && rf_dirty[s];
        e_st = 0; e_ld = 0; e_wr = 0; e_nd = 0; e_nc = 0; e_fin = 0;
        if (is_flush) begin
            if (hit && dirty) begin e_st = WORDS; e_nd = 1; exp_wbacks++; end
        end else if (hit) begin
            e_wr = is_store ? 1 : 0;
            exp_hits++;
        end else begin
            e_st = dirty ? WORDS : 0; e_nd = dirty ? 1 : 0; e_nc = 1;
            e_ld = WORDS; e_wr = WORDS + (is_store ? 1 : 0); e_fin = 1;
            exp_misses++;
            if (dirty) exp_wbacks++;
        end

        n_st = 0; n_ld = 0; n_wr = 0; n_nd = 0; n_nc = 0; n_fin = 0; proto = 0;
        cyc = 0; ful_cyc = 0; done = 0; aborted = 0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            pipe_req_valid    = 1'b1;
            pipe_req_type     = typ;
            valid_block_match = dp_valid[s] && (dp_tag[s] == t);
            valid_dirty_bit   = dp_valid[s] && dp_dirty[s];
            counter_done      = (dp_cnt == 0);
            l2_req_fulfilled  = l2_busy && (l2_wait == 0);
            if (l2_busy && l2_wait > 0) l2_wait--;
            #1;
            cyc++;
            if (l2_busy && !l2_req_valid) proto++;
            if (l2_req_valid) begin
                if (l2_busy && l2_req_store != l2_store_lat) proto++;
                if (l2_req_fulfilled) begin
                    if (l2_req_store) n_st++; else n_ld++;
                    l2_busy = 1'b0;
                end else if (!l2_busy) begin
                    l2_busy      = 1'b1;
                    l2_store_lat = l2_req_store;
                    l2_wait      = $urandom_range(0, 3);
                end
            end
            if (flush_mode !== (l2_req_valid && l2_req_store)) proto++;
            if (load_mode !== (l2_req_valid && !l2_req_store)) proto++;
            if (set_selected_dirty_bit && clear_selected_dirty_bit) proto++;
            if (finish_new_line_install && clear_selected_valid_bit) proto++;
            if (perform_write) n_wr++;
            if (set_new_l2_block_address) begin
                if (use_dirty_tag_for_l2_block_address) n_nd++; else n_nc++;
            end
            if (finish_new_line_install) begin n_fin++; dp_valid[s] = 1'b1; dp_tag[s] = t; end
            if (set_selected_dirty_bit) dp_dirty[s] = 1'b1;
            if (clear_selected_dirty_bit) dp_dirty[s] = 1'b0;
            if (clear_selected_valid_bit) dp_valid[s] = 1'b0;
            if (reset_counter) dp_cnt = WORDS - 1;
            else if (decrement_counter) dp_cnt--;
            if (pipe_req_fulfilled) begin ful_cyc = cyc; done = 1'b1; end
            if (abort && load_mode && n_ld == 4) begin aborted = 1'b1; done = 1'b1; end
        end
        chk({nm, "_completed"}, done, 1);

        if (aborted) begin
            @(negedge clk);
            reset_n = 1'b0; pipe_req_valid = 1'b0; l2_req_fulfilled = 1'b0; l2_busy = 1'b0;
            #1 chk({nm, "_outs_in_reset"}, outs, 0);
            exp_hits = 0; exp_misses = 0; exp_wbacks = 0;
            chk_perf({nm, "_reset"});
            @(negedge clk);
            reset_n = 1'b1;
            #1 chk({nm, "_outs_after_reset"}, outs, 0);
            rf_valid[s] = 1'b0; rf_dirty[s] = 1'b0;
        end else begin
            chk({nm, "_l2_stores"}, n_st, e_st);
            chk({nm, "_l2_loads"}, n_ld, e_ld);
            chk({nm, "_writes"}, n_wr, e_wr);
            chk({nm, "_new_addr_dirty"}, n_nd, e_nd);
            chk({nm, "_new_addr_clean"}, n_nc, e_nc);
            chk({nm, "_installs"}, n_fin, e_fin);
            if (e_st == 0 && e_ld == 0) chk({nm, "_latency"}, ful_cyc, 2);
            if (is_flush) begin
                if (hit) begin rf_valid[s] = 1'b0; rf_dirty[s] = 1'b0; end
            end else begin
                if (!hit) begin rf_valid[s] = 1'b1; rf_tag[s] = t; rf_dirty[s] = 1'b0; end
                if (is_store) rf_dirty[s] = 1'b1;
            end
            @(negedge clk);
            pipe_req_valid = 1'b0; l2_req_fulfilled = 1'b0;
            #1 chk({nm, "_idle_outs"}, outs, 0);
        end
        chk({nm, "_protocol"}, proto, 0);
        chk({nm, "_valid"}, dp_valid[s], rf_valid[s]);
        if (rf_valid[s]) chk({nm, "_tag"}, dp_tag[s], rf_tag[s]);
        chk({nm, "_dirty"}, dp_dirty[s], rf_dirty[s]);
        chk_perf(nm);
    endtask

    initial begin
        for (int i = 0; i < SETS; i++) begin
            dp_valid[i] = 1'b0; dp_tag[i] = 0; dp_dirty[i] = 1'b0;
            rf_valid[i] = 1'b0; rf_tag[i] = 0; rf_dirty[i] = 1'b0;
        end
        dp_cnt = 0; l2_busy = 1'b0; l2_wait = 0; l2_store_lat = 1'b0;
        exp_hits = 0; exp_misses = 0; exp_wbacks = 0;
        pipe_req_valid = 1'b0; pipe_req_type = 2'd0; l2_req_fulfilled = 1'b0;
        valid_block_match = 1'b0; valid_dirty_bit = 1'b0; counter_done = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", outs, 0);
        chk_perf("reset");
        @(negedge clk);
        reset_n = 1'b1;

        do_req(2'd0, 0, 1, 1'b0);   // load miss, clean victim
        do_req(2'd0, 0, 1, 1'b0);   // load hit
        do_req(2'd1, 0, 1, 1'b0);   // store hit
        do_req(2'd1, 0, 2, 1'b0);   // store miss, dirty victim
        do_req(2'd2, 0, 2, 1'b0);   // clflush dirty hit
        do_req(2'd2, 0, 2, 1'b0);   // clflush miss
        do_req(2'd3, 2, 0, 1'b0);   // reserved type behaves as load miss
        do_req(2'd2, 2, 0, 1'b0);   // clflush clean hit
        do_req(2'd0, 1, 3, 1'b1);   // load miss interrupted by reset mid-refill
        do_req(2'd0, 1, 3, 1'b0);   // same load misses again

        for (int i = 0; i < 40; i++) begin
            do_req(2'($urandom_range(0, 3)), int'($urandom_range(0, SETS - 1)),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
